// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator. Generates sclk and cs_n, shifts txData out
// MSB-first on mosi and assembles the returned word from miso.
//
// Control handshake: start is a request that is taken on any rising clk edge
// where busy==0 (the done cycle included); busy then stays high until the
// edge that raises done for exactly one cycle, at which point rxData holds the
// received word. start seen while busy==1 is dropped, never queued.
//
// Every output is a flop. The FSM state is kept in the signal 'state' so
// checkers can bind to it directly.
module spi_master #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] txData,
   input  logic             miso,
   output logic [WIDTH-1:0] rxData,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      HIGH   = 3'd2,
      LOW    = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   logic [CW-1:0]    half_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] tx_next;
   logic [WIDTH-1:0] rx_shift;
   logic             half_done;

   // One-cycle strobes telling the datapath which event happens on this edge.
   logic do_accept;
   logic do_rise;
   logic do_fall;
   logic do_shift;
   logic do_finish;

   assign half_done = (half_cnt == HALF_LAST);
   assign tx_next   = tx_shift << 1;

   // Next-state decode and event strobes; each non-idle state lasts one half-period.
   always_comb begin
      state_next = state;
      do_accept  = 1'b0;
      do_rise    = 1'b0;
      do_fall    = 1'b0;
      do_shift   = 1'b0;
      do_finish  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               do_accept  = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (half_done) begin
               do_rise    = 1'b1;
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (half_done) begin
               do_fall = 1'b1;
               if (bit_cnt != BIT_LAST) begin
                  do_shift   = 1'b1;
                  state_next = LOW;
               end else begin
                  state_next = FINISH;
               end
            end
         end
         LOW: begin
            if (half_done) begin
               do_rise    = 1'b1;
               state_next = HIGH;
            end
         end
         FINISH: begin
            if (half_done) begin
               do_finish  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Half-period counter: held at zero in IDLE so every phase starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         half_cnt <= '0;
      else if (state == IDLE || half_done) half_cnt <= '0;
      else                                half_cnt <= half_cnt + CW'(1);
   end

   // Bit counter: number of falling sclk edges that advanced mosi so far.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         bit_cnt <= '0;
      else if (do_accept) bit_cnt <= '0;
      else if (do_shift)  bit_cnt <= bit_cnt + BW'(1);
   end

   // Transmit path: mosi changes only at accept and on falling sclk, so it is
   // stable for a full half-period before each rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '0;
         mosi     <= 1'b0;
      end else if (do_accept) begin
         tx_shift <= txData;
         mosi     <= txData[WIDTH-1];
      end else if (do_shift) begin
         tx_shift <= tx_next;
         mosi     <= tx_next[WIDTH-1];
      end else if (do_finish) begin
         mosi     <= 1'b0;
      end
   end

   // Receive path: sample miso together with each rising sclk, shifting left
   // so the first sampled bit lands in the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         rx_shift <= '0;
      else if (do_accept) rx_shift <= '0;
      else if (do_rise)   rx_shift <= (rx_shift << 1) | WIDTH'(miso);
   end

   // Pin and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk   <= 1'b0;
         cs_n   <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         rxData <= '0;
      end else begin
         done <= do_finish;
         if (do_rise)      sclk <= 1'b1;
         else if (do_fall) sclk <= 1'b0;
         if (do_accept) begin
            cs_n <= 1'b0;
            busy <= 1'b1;
         end else if (do_finish) begin
            cs_n   <= 1'b1;
            busy   <= 1'b0;
            rxData <= rx_shift;
         end
      end
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI-style master: the initiator end of the serial link whose peripheral side is the team's shift register.
- Generates the serial clock and active-low chip select, shifts a parallel word out MSB-first, and captures the returned word.
- Mode 0 timing: the peripheral updates its output on the falling edge and samples its input on the rising edge. The master does the same: it drives mosi so it is stable before each rising edge and samples miso on each rising edge.
- Sits between the FPGA-side control logic (start/busy/done) and the external pins.

Parameters:
- WIDTH, 8, bits per transaction.
- CLK_DIV, 4, clk cycles per sclk half-period. Minimum 2. The peripheral must update miso within CLK_DIV-1 clk cycles of a falling sclk.

Ports:
- clk  input  1  fpga clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a transaction; honoured only when busy==0.
- txData  input  WIDTH  word to send; captured on the accepting edge.
- miso  input  1  serial data from the peripheral.
- rxData  output  WIDTH  last received word; updated only on completion.
- busy  output  1  high from acceptance through completion.
- done  output  1  one-cycle pulse on completion.
- sclk  output  1  serial clock; idles low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data to the peripheral; MSB first.

Behaviour:
- Reset (async assert, sync release): cs_n=1, sclk=0, mosi=0, busy=0, done=0, rxData=0, state=IDLE, counters=0. Reset mid-transaction aborts immediately: cs_n deasserts, no done pulse, rxData=0.
- States: IDLE, SETUP, HIGH, LOW, FINISH. A half-period counter counts 0..CLK_DIV-1; a bit counter counts 0..WIDTH-1.
- Accepting edge E0 (IDLE, start=1):
  - txData latched into the tx shift register.
  - cs_n←0, busy←1, mosi←txData[WIDTH-1], sclk stays 0; go to SETUP.
- SETUP: after CLK_DIV cycles (edge E0+CLK_DIV): sclk←1, miso sampled into the rx shift LSB (rx shifts left); go to HIGH.
- Rising edge k (k=1..WIDTH) at E0+(2k-1)·CLK_DIV; falling edge k at E0+2k·CLK_DIV.
- HIGH: after CLK_DIV cycles: sclk←0.
  - If bit counter < WIDTH-1: tx shifts left, mosi←next bit, bit counter++; go to LOW.
  - Else: go to FINISH; mosi holds the last bit.
- LOW: after CLK_DIV cycles: sclk←1, sample miso; go to HIGH.
- FINISH: after CLK_DIV cycles (edge E0+(2·WIDTH+1)·CLK_DIV):
  - cs_n←1, busy←0, done←1 for one cycle, rxData←rx shift register, mosi←0; go to IDLE.
- Exactly WIDTH rising and WIDTH falling sclk edges per transaction. sclk never toggles while cs_n=1.
- Received bit order: the first bit sampled ends up in rxData[WIDTH-1].
- start while busy=1: ignored, no queueing. txData changes after acceptance have no effect.
- start asserted in the done cycle: accepted, since busy is already 0. cs_n is then high for exactly one clk cycle between transactions.
- rxData holds its value until the next completion or reset.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Loopback (miso=mosi), WIDTH=8, CLK_DIV=4, start with txData=0xA5 -> mosi bits 1,0,1,0,0,1,0,1; rxData=0xA5; done pulses once, 68 cycles after the accepting edge; busy high for exactly 68 cycles.
- Edge timing, CLK_DIV=4: sclk rises at E0+4,12,…,60 and falls at E0+8,…,64; cs_n low from E0 to E0+68; mosi is never sampled changing within one clk of a rising sclk.
- miso tied 1, txData=0x00 -> rxData=0xFF, mosi constant 0. Then miso tied 0, txData=0xFF -> rxData=0x00.
- Peripheral model: the team's shift register preloaded with 0x5A, clocked by a falling-edge detector on sclk; master sends 0x3C -> master rxData=0x5A, peripheral parallel out=0x3C.
- start pulsed at E0+20 mid-transaction with txData=0x11 -> ignored; the first transaction completes unchanged; no second done.
- rst_n low at E0+30 -> cs_n=1 and sclk=0 immediately (before the next clk edge), busy=0, rxData=0, no done. After release, a start with 0xC3 completes normally with loopback rxData=0xC3.
- Back-to-back: start held high through the done cycle -> second transaction accepted on the next edge; cs_n high for exactly one cycle; both rxData values correct.
